// File: rtl/fill_drain_pkg.sv
// fill_drain_pkg: shared AXI constants, default width macros and fill-entry layout helpers.
// Rev 1.0 - initial release.
`default_nettype none

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 512
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ID
`define AXI_ID 0
`endif

package fill_drain_pkg;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Fill entry is {addr, data}: address field starts right above the data field.
  function automatic int unsigned fill_addr_lsb(input int unsigned data_width);
    return data_width;
  endfunction

  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fill_drain_if.sv
// fill_drain_if: cache-side AXI write channels (AW/W/B) between fill_drain and the data array.
// Rev 1.0 - initial release.
`default_nettype none

interface fill_drain_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid_o;
  logic [ADDR_WIDTH-1:0]   awaddr_o;
  logic [7:0]              awlen_o;
  logic [2:0]              awsize_o;
  logic [1:0]              awburst_o;
  logic                    awvalid_o;
  logic                    awready_i;
  logic [DATA_WIDTH-1:0]   wdata_o;
  logic [DATA_WIDTH/8-1:0] wstrb_o;
  logic                    wlast_o;
  logic                    wvalid_o;
  logic                    wready_i;
  logic [ID_WIDTH-1:0]     bid_i;
  logic [1:0]              bresp_i;
  logic                    bvalid_i;
  logic                    bready_o;

  modport master (
    output awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
    output wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o,
    input  awready_i, wready_i, bid_i, bresp_i, bvalid_i
  );

  modport slave (
    input  awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
    input  wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o,
    output awready_i, wready_i, bid_i, bresp_i, bvalid_i
  );
endinterface

`default_nettype wire

// File: rtl/fill_drain.sv
// fill_drain: pops Fill FIFO entries and issues each as a single-beat AXI write, flagging error responses.
// Optional fill/error counters enabled by defining FILL_DRAIN_STAT_EN.  Rev 1.0 - initial release.
`default_nettype none

module fill_drain
  import fill_drain_pkg::*;
#(
  parameter int          ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int          DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int          ID_WIDTH   = `AXI_ID_WIDTH,
  parameter int unsigned ID         = `AXI_ID
) (
  input  wire logic                             clk,
  input  wire logic                             rst_n,
  input  wire logic                             fill_fifo_empty_i,
  output logic                                  fill_fifo_rden_o,
  input  wire logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_fifo_data_i,
  fill_drain_if.master                          axi,
  output logic                                  drain_idle_o,
  output logic                                  wr_err_o
`ifdef FILL_DRAIN_STAT_EN
  ,
  output logic [31:0]                           fill_cnt_o,
  output logic [31:0]                           err_cnt_o
`endif
);

  localparam int ADDR_LSB = fill_addr_lsb(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_REQ  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_aw_done;
  logic   r_w_done;
  logic   w_aw_hs;
  logic   w_w_hs;
  logic   w_aw_fin;
  logic   w_w_fin;
  logic   w_b_hs;
  logic   w_unused_bid;

  assign w_aw_hs      = axi.awvalid_o & axi.awready_i;
  assign w_w_hs       = axi.wvalid_o & axi.wready_i;
  assign w_aw_fin     = r_aw_done | w_aw_hs;
  assign w_w_fin      = r_w_done | w_w_hs;
  assign w_b_hs       = axi.bvalid_i & axi.bready_o;
  assign w_unused_bid = ^axi.bid_i;

  assign axi.awid_o    = ID_WIDTH'(ID);
  assign axi.awlen_o   = 8'd0;
  assign axi.awsize_o  = axi_size(DATA_WIDTH);
  assign axi.awburst_o = AXI_BURST_INCR;
  assign axi.wstrb_o   = '1;
  assign axi.wlast_o   = 1'b1;
  assign drain_idle_o  = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    fill_fifo_rden_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fill_fifo_empty_i) begin
          fill_fifo_rden_o = 1'b1;
          w_next           = S_LOAD;
        end
      end
      S_LOAD:  w_next = S_REQ;
      S_REQ:   if (w_aw_fin && w_w_fin) w_next = S_RESP;
      S_RESP:  if (w_b_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // AW and W complete independently; the done flags remember whichever finished first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi.awaddr_o  <= '0;
      axi.wdata_o   <= '0;
      axi.awvalid_o <= 1'b0;
      axi.wvalid_o  <= 1'b0;
      axi.bready_o  <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      wr_err_o      <= 1'b0;
    end else begin
      wr_err_o <= 1'b0;
      case (r_state)
        S_LOAD: begin
          axi.awaddr_o  <= fill_fifo_data_i[ADDR_LSB +: ADDR_WIDTH];
          axi.wdata_o   <= fill_fifo_data_i[DATA_WIDTH-1:0];
          axi.awvalid_o <= 1'b1;
          axi.wvalid_o  <= 1'b1;
          r_aw_done     <= 1'b0;
          r_w_done      <= 1'b0;
        end
        S_REQ: begin
          if (w_aw_hs) begin
            axi.awvalid_o <= 1'b0;
            r_aw_done     <= 1'b1;
          end
          if (w_w_hs) begin
            axi.wvalid_o <= 1'b0;
            r_w_done     <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            axi.bready_o <= 1'b1;
          end
        end
        S_RESP: begin
          if (w_b_hs) begin
            axi.bready_o <= 1'b0;
            wr_err_o     <= (axi.bresp_i != AXI_RESP_OKAY);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FILL_DRAIN_STAT_EN
  logic [31:0] r_fill_cnt;
  logic [31:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt <= 32'd0;
      r_err_cnt  <= 32'd0;
    end else begin
      if (w_b_hs)   r_fill_cnt <= r_fill_cnt + 32'd1;
      if (wr_err_o) r_err_cnt  <= r_err_cnt + 32'd1;
    end
  end

  assign fill_cnt_o = r_fill_cnt;
  assign err_cnt_o  = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fill_drain.sv
// tb_fill_drain: scoreboard bench for fill_drain with a Fill FIFO model and an AXI write slave.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module tb_fill_drain;
  import fill_drain_pkg::*;

  localparam int AW = 32;
  localparam int DW = 512;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            fifo_empty;
  logic            fifo_rden;
  logic [AW+DW-1:0] fifo_dout = '0;
  logic            drain_idle;
  logic            wr_err;
`ifdef FILL_DRAIN_STAT_EN
  logic [31:0]     fill_cnt;
  logic [31:0]     err_cnt;
`endif

  fill_drain_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi();

  fill_drain #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .ID(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fill_fifo_empty_i (fifo_empty),
    .fill_fifo_rden_o  (fifo_rden),
    .fill_fifo_data_i  (fifo_dout),
    .axi               (axi),
    .drain_idle_o      (drain_idle),
    .wr_err_o          (wr_err)
`ifdef FILL_DRAIN_STAT_EN
    ,
    .fill_cnt_o        (fill_cnt),
    .err_cnt_o         (err_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tally(input bit ok, input string msg);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tally(act === exp, $sformatf("%s: got %b, want %b", name, act, exp));
  endtask

  task automatic chki(input string name, input int act, input int exp);
    tally(act == exp, $sformatf("%s: got %0d, want %0d", name, act, exp));
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    tally(act === exp, $sformatf("%s: got %h, want %h", name, act, exp));
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tally(act === exp, $sformatf("%s: got %h, want %h", name, act, exp));
  endtask

  // Fill FIFO model: 1-cycle read latency
  logic [AW+DW-1:0] mem [0:15];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_dout <= mem[rp[3:0]];
      rp        <= rp + 1;
    end
  end

  // Scoreboard queues, filled when stimulus is issued
  logic [AW-1:0] exp_aw_q[$];
  logic [DW-1:0] exp_w_q[$];
  logic          exp_b_q[$];
  logic [1:0]    resp_q[$];

  task automatic push_entry(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [1:0] resp);
    mem[wp[3:0]] = {addr, data};
    wp++;
    exp_aw_q.push_back(addr);
    exp_w_q.push_back(data);
    exp_b_q.push_back(resp != 2'b00);
    resp_q.push_back(resp);
  endtask

  // AXI write slave: B follows one cycle after both AW and W have completed
  logic aw_seen;
  logic w_seen;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_seen      <= 1'b0;
      w_seen       <= 1'b0;
      axi.bvalid_i <= 1'b0;
      axi.bresp_i  <= 2'b00;
    end else if (axi.bvalid_i && axi.bready_o) begin
      axi.bvalid_i <= 1'b0;
    end else if (!axi.bvalid_i && (aw_seen || (axi.awvalid_o && axi.awready_i))
                              && (w_seen || (axi.wvalid_o && axi.wready_i))) begin
      axi.bvalid_i <= 1'b1;
      if (resp_q.size() > 0) axi.bresp_i <= resp_q.pop_front();
      else axi.bresp_i <= 2'b00;
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
    end else begin
      if (axi.awvalid_o && axi.awready_i) aw_seen <= 1'b1;
      if (axi.wvalid_o && axi.wready_i) w_seen <= 1'b1;
    end
  end

  // Monitor: samples late in the low phase, after stimulus has settled
  int   rden_cnt = 0;
  int   b_cnt    = 0;
  logic busy     = 1'b0;
  logic pend     = 1'b0;
  logic pend_val = 1'b0;

  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    #3;
    if (!rst_n) begin
      busy = 1'b0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk1("wr_err pulse after B", wr_err, pend_val);
        pend = 1'b0;
      end else if (wr_err) begin
        chk1("wr_err spurious", wr_err, 1'b0);
      end
      if (fifo_rden) begin
        chk1("rden with write outstanding", busy, 1'b0);
        busy = 1'b1;
        rden_cnt++;
      end
      if (axi.awvalid_o && axi.awready_i) begin
        if (exp_aw_q.size() == 0) begin
          chk1("unexpected AW beat", 1'b1, 1'b0);
        end else begin
          ea = exp_aw_q.pop_front();
          chka("awaddr", axi.awaddr_o, ea);
          chki("aw id/len/size/burst", int'({axi.awid_o, axi.awlen_o, axi.awsize_o, axi.awburst_o}),
               int'({4'd5, 8'd0, 3'd6, 2'b01}));
        end
      end
      if (axi.wvalid_o && axi.wready_i) begin
        if (exp_w_q.size() == 0) begin
          chk1("unexpected W beat", 1'b1, 1'b0);
        end else begin
          ed = exp_w_q.pop_front();
          chkw("wdata", axi.wdata_o, ed);
          chk1("wlast", axi.wlast_o, 1'b1);
          chk1("wstrb all ones", &axi.wstrb_o, 1'b1);
        end
      end
      if (axi.bvalid_i && axi.bready_o) begin
        pend     = 1'b1;
        pend_val = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 1'b0;
        busy     = 1'b0;
        b_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rden(input string name);
    int n;
    n = 0;
    #1;
    while (!fifo_rden && n < 50) begin
      tick();
      n++;
    end
    chk1({name, " rden seen"}, fifo_rden, 1'b1);
  endtask

  task automatic wait_b(input string name, input int target);
    int n;
    n = 0;
    while (b_cnt < target && n < 200) begin
      tick();
      n++;
    end
    chki({name, " B handshakes"}, b_cnt, target);
  endtask

  initial begin
    int base;
    bit bad;
    axi.awready_i = 1'b1;
    axi.wready_i  = 1'b1;
    axi.bid_i     = '0;
    rst_n         = 1'b0;
    repeat (3) tick();

    chk1("reset awvalid", axi.awvalid_o, 1'b0);
    chk1("reset wvalid", axi.wvalid_o, 1'b0);
    chk1("reset bready", axi.bready_o, 1'b0);
    chk1("reset rden", fifo_rden, 1'b0);
    chk1("reset wr_err", wr_err, 1'b0);
    chk1("reset idle", drain_idle, 1'b1);
    chka("reset awaddr", axi.awaddr_o, '0);
    chkw("reset wdata", axi.wdata_o, '0);
`ifdef FILL_DRAIN_STAT_EN
    chki("reset fill_cnt", int'(fill_cnt), 0);
    chki("reset err_cnt", int'(err_cnt), 0);
`endif
    rst_n = 1'b1;
    tick();

    // Single write, immediate responses, idle again 4 cycles after the pop
    push_entry(32'h0000_1040, {64{8'hA5}}, 2'b00);
    wait_rden("t1");
    tick();
    chk1("t1 rden single cycle", fifo_rden, 1'b0);
    tick();
    tick();
    chk1("t1 busy at pop+3", drain_idle, 1'b0);
    tick();
    chk1("t1 idle at pop+4", drain_idle, 1'b1);
    chki("t1 B count", b_cnt, 1);

    // AW stalled 5 cycles, W accepted immediately
    axi.awready_i = 1'b0;
    push_entry(32'h0000_2080, {16{32'hDEAD_BEEF}}, 2'b00);
    wait_rden("t2");
    tick();
    tick();
    chk1("t2 awvalid raised", axi.awvalid_o, 1'b1);
    chk1("t2 wvalid raised", axi.wvalid_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("t2 wvalid cleared", axi.wvalid_o, 1'b0);
      chk1("t2 awvalid held", axi.awvalid_o, 1'b1);
      chka("t2 awaddr stable", axi.awaddr_o, 32'h0000_2080);
      chk1("t2 bready held low", axi.bready_o, 1'b0);
    end
    axi.awready_i = 1'b1;
    tick();
    chk1("t2 awvalid cleared", axi.awvalid_o, 1'b0);
    chk1("t2 bready after AW", axi.bready_o, 1'b1);
    wait_b("t2", 2);

    // Three back-to-back entries drained in FIFO order
    base = rden_cnt;
    push_entry(32'h0000_3000, {8{64'h0123_4567_89AB_CDEF}}, 2'b00);
    push_entry(32'h0000_3040, {8{64'hFEDC_BA98_7654_3210}}, 2'b00);
    push_entry(32'h0000_3080, {32{16'h5A3C}}, 2'b00);
    wait_b("t3", 5);
    repeat (3) tick();
    chki("t3 rden pulses", rden_cnt - base, 3);

    // Asynchronous reset while the request is outstanding
    axi.awready_i = 1'b0;
    axi.wready_i  = 1'b0;
    push_entry(32'h0000_4000, {64{8'h3C}}, 2'b00);
    wait_rden("t5");
    tick();
    tick();
    chk1("t5 awvalid before reset", axi.awvalid_o, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("t5 awvalid async drop", axi.awvalid_o, 1'b0);
    chk1("t5 wvalid async drop", axi.wvalid_o, 1'b0);
    chk1("t5 bready async drop", axi.bready_o, 1'b0);
    chk1("t5 idle in reset", drain_idle, 1'b1);
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_b_q.delete();
    resp_q.delete();
    tick();
    tick();
    rst_n         = 1'b1;
    axi.awready_i = 1'b1;
    axi.wready_i  = 1'b1;
    tick();

    // Two writes, the second answered with SLVERR
    base = b_cnt;
    push_entry(32'h0000_5000, {64{8'h11}}, 2'b00);
    push_entry(32'h0000_5040, {64{8'h22}}, 2'b10);
    wait_b("t4", base + 2);
    chk1("t4 wr_err on error response", wr_err, 1'b1);
`ifdef FILL_DRAIN_STAT_EN
    chki("t4 fill_cnt", int'(fill_cnt), 2);
    chki("t4 err_cnt before update", int'(err_cnt), 0);
`endif
    tick();
    chk1("t4 wr_err one cycle", wr_err, 1'b0);
`ifdef FILL_DRAIN_STAT_EN
    chki("t4 err_cnt", int'(err_cnt), 1);
`endif

    // Empty FIFO for 100 cycles: no activity
    base = rden_cnt;
    bad  = 1'b0;
    repeat (100) begin
      tick();
      if (fifo_rden || axi.awvalid_o || axi.wvalid_o || axi.bready_o || !drain_idle) bad = 1'b1;
    end
    chk1("t6 quiet while empty", bad, 1'b0);
    chki("t6 no rden", rden_cnt - base, 0);
    chki("scoreboard AW drained", exp_aw_q.size(), 0);
    chki("scoreboard W drained", exp_w_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
